gpr_mp: RTL and testbench



---
 rtl/gpr_mp.sv | 112 +++++++++++
 tb/tb_gpr_mp.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file: NUM_RD combinational read ports, two write
// ports (port 1 wins on collision), hardwired zero register, optional bypass, pending scoreboard.
module gpr_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam bit          ZERO_EN = (ZERO_REG != 0);
  localparam bit          BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic wr0_en;
  logic wr1_en;
  logic rsv_ok;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == '0);
  endfunction

  // Anything presented while rst is high is discarded, including the bypass path,
  // so every read port shows zero for the whole reset interval.
  assign wr0_en = we0 & ~rst & ~is_zero_reg(waddr0);
  assign wr1_en = we1 & ~rst & ~is_zero_reg(waddr1);
  assign rsv_ok = rsv_en & ~rst & ~is_zero_reg(rsv_addr);

  // Port 1 is applied last so it owns a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (wr0_en) regs_d[waddr0] = wdata0;
    if (wr1_en) regs_d[waddr1] = wdata1;
  end

  // Writebacks clear, then a reservation sets: the newer producer wins a race.
  always_comb begin
    pend_d = pend_q;
    if (wr0_en) pend_d[waddr0] = 1'b0;
    if (wr1_en) pend_d[waddr1] = 1'b0;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rd;
    logic              busy;

    assign ra   = raddr[k*ADDR_W +: ADDR_W];
    assign hit0 = BYP_EN && wr0_en && (waddr0 == ra);
    assign hit1 = BYP_EN && wr1_en && (waddr1 == ra);

    // A same-cycle writeback both forwards its data and hides the pending bit.
    always_comb begin
      rd   = regs_q[ra];
      busy = pend_q[ra];
      if (hit1) begin
        rd = wdata1;
      end else if (hit0) begin
        rd = wdata0;
      end
      if (hit0 || hit1) begin
        busy = 1'b0;
      end
      if (is_zero_reg(ra)) begin
        rd   = '0;
        busy = 1'b0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
    assign rbusy[k]                  = busy;
  end

  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: directed scenarios plus a randomized run against a behavioural model,
// on a bypassing zero-register instance (u_a) and a plain 16x8, 4-read-port instance (u_b).
module tb_gpr_mp;

  logic        clk;
  logic        rst;

  logic        a_we0, a_we1, a_rsv_en;
  logic [4:0]  a_waddr0, a_waddr1, a_rsv_addr, a_dbg_addr;
  logic [31:0] a_wdata0, a_wdata1, a_dbg_data;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;

  logic        b_we0, b_we1, b_rsv_en;
  logic [2:0]  b_waddr0, b_waddr1, b_rsv_addr, b_dbg_addr;
  logic [15:0] b_wdata0, b_wdata1, b_dbg_data;
  logic [11:0] b_raddr;
  logic [63:0] b_rdata;
  logic [3:0]  b_rbusy;

  int n_tests;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] ma_reg [32];
  logic        ma_pend [32];
  logic [15:0] mb_reg [8];
  logic        mb_pend [8];

  gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst),
    .we0(a_we0), .waddr0(a_waddr0), .wdata0(a_wdata0),
    .we1(a_we1), .waddr1(a_waddr1), .wdata1(a_wdata1),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
  );

  gpr_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst),
    .we0(b_we0), .waddr0(b_waddr0), .wdata0(b_wdata0),
    .we1(b_we1), .waddr1(b_waddr1), .wdata1(b_wdata1),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_we0 = 1'b0; a_waddr0 = '0; a_wdata0 = '0;
    a_we1 = 1'b0; a_waddr1 = '0; a_wdata1 = '0;
    a_rsv_en = 1'b0; a_rsv_addr = '0;
    b_we0 = 1'b0; b_waddr0 = '0; b_wdata0 = '0;
    b_we1 = 1'b0; b_waddr1 = '0; b_wdata1 = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0;
  endtask

  function automatic logic [4:0] rand_a();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    a_raddr = {5'd5, 5'd5}; a_dbg_addr = 5'd5;
    b_raddr = '0;           b_dbg_addr = 3'd0;
    #12;
    n_tests++; if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_a_rdata: got %h expected 0", a_rdata); end
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL reset_a_rbusy: got %b expected 00", a_rbusy); end
    n_tests++; if (a_dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_a_dbg: got %h expected 0", a_dbg_data); end
    n_tests++; if (b_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_b_rdata: got %h expected 0", b_rdata); end
    n_tests++; if (b_rbusy !== 4'h0) begin n_fail++; $display("FAIL reset_b_rbusy: got %b expected 0000", b_rbusy); end
    n_tests++; if (b_dbg_data !== 16'h0) begin n_fail++; $display("FAIL reset_b_dbg: got %h expected 0", b_dbg_data); end
    tick();
    rst = 1'b0;
    a_we0 = 1'b1; a_waddr0 = 5'd5; a_wdata0 = 32'h0BAD_F00D;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
    tick();
    idle_inputs();
    a_raddr = {5'd6, 5'd5};
    #2;
    n_tests++; if (a_dbg_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL pre_reset_dbg: got %h expected 0badf00d", a_dbg_data); end
    n_tests++; if (a_rbusy !== 2'b10) begin n_fail++; $display("FAIL pre_reset_rbusy: got %b expected 10", a_rbusy); end
    // asynchronous mid-stream reset with traffic presented during it
    #1;
    rst = 1'b1;
    a_we0 = 1'b1; a_waddr0 = 5'd5; a_wdata0 = 32'h0000_0077;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
    #1;
    n_tests++; if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL midreset_rdata: got %h expected 0", a_rdata); end
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL midreset_rbusy: got %b expected 00", a_rbusy); end
    n_tests++; if (a_dbg_data !== 32'h0) begin n_fail++; $display("FAIL midreset_dbg: got %h expected 0", a_dbg_data); end
    tick();
    rst = 1'b0;
    idle_inputs();
    #2;
    n_tests++; if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL postreset_rdata: got %h expected 0", a_rdata); end
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL postreset_rbusy: got %b expected 00", a_rbusy); end
  endtask

  task automatic test_write_read();
    tick();
    a_we0 = 1'b1; a_waddr0 = 5'd5; a_wdata0 = 32'hDEAD_BEEF;
    a_raddr = {5'd5, 5'd5}; a_dbg_addr = 5'd5;
    b_we0 = 1'b1; b_waddr0 = 3'd5; b_wdata0 = 16'hBEEF;
    b_raddr = {4{3'd5}}; b_dbg_addr = 3'd5;
    #2;
    n_tests++; if (a_rdata !== {2{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL wr_bypass_a: got %h expected deadbeef x2", a_rdata); end
    n_tests++; if (a_dbg_data !== 32'h0) begin n_fail++; $display("FAIL wr_dbg_same_cycle: got %h expected 0", a_dbg_data); end
    n_tests++; if (b_rdata !== 64'h0) begin n_fail++; $display("FAIL wr_nobypass_b: got %h expected 0", b_rdata); end
    tick();
    idle_inputs();
    #2;
    n_tests++; if (a_rdata !== {2{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL wr_stored_a: got %h expected deadbeef x2", a_rdata); end
    n_tests++; if (a_dbg_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_dbg_next: got %h expected deadbeef", a_dbg_data); end
    n_tests++; if (b_rdata !== {4{16'hBEEF}}) begin n_fail++; $display("FAIL wr_stored_b: got %h expected beef x4", b_rdata); end
    n_tests++; if (b_dbg_data !== 16'hBEEF) begin n_fail++; $display("FAIL wr_dbg_b: got %h expected beef", b_dbg_data); end
  endtask

  task automatic test_zero_reg();
    tick();
    a_we0 = 1'b1; a_waddr0 = 5'd0; a_wdata0 = 32'h1234;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    a_raddr = '0; a_dbg_addr = 5'd0;
    b_we0 = 1'b1; b_waddr0 = 3'd0; b_wdata0 = 16'h1234;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd0;
    b_raddr = '0; b_dbg_addr = 3'd0;
    #2;
    n_tests++; if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL zero_same_rdata: got %h expected 0", a_rdata); end
    n_tests++; if (b_rbusy !== 4'h0) begin n_fail++; $display("FAIL zero_b_rsv_same: got %b expected 0000", b_rbusy); end
    tick();
    idle_inputs();
    #2;
    n_tests++; if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL zero_rdata: got %h expected 0", a_rdata); end
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL zero_rbusy: got %b expected 00", a_rbusy); end
    n_tests++; if (a_dbg_data !== 32'h0) begin n_fail++; $display("FAIL zero_dbg: got %h expected 0", a_dbg_data); end
    n_tests++; if (b_rdata !== {4{16'h1234}}) begin n_fail++; $display("FAIL nozero_rdata: got %h expected 1234 x4", b_rdata); end
    n_tests++; if (b_rbusy !== 4'hF) begin n_fail++; $display("FAIL nozero_rbusy: got %b expected 1111", b_rbusy); end
    n_tests++; if (b_dbg_data !== 16'h1234) begin n_fail++; $display("FAIL nozero_dbg: got %h expected 1234", b_dbg_data); end
    tick();
    #2;
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL zero_rbusy_later: got %b expected 00", a_rbusy); end
    n_tests++; if (b_rbusy !== 4'hF) begin n_fail++; $display("FAIL nozero_rbusy_later: got %b expected 1111", b_rbusy); end
  endtask

  task automatic test_collision();
    tick();
    a_we0 = 1'b1; a_waddr0 = 5'd7; a_wdata0 = 32'h1111;
    a_we1 = 1'b1; a_waddr1 = 5'd7; a_wdata1 = 32'h2222;
    a_raddr = {5'd7, 5'd7}; a_dbg_addr = 5'd7;
    b_we0 = 1'b1; b_waddr0 = 3'd7; b_wdata0 = 16'h1111;
    b_we1 = 1'b1; b_waddr1 = 3'd7; b_wdata1 = 16'h2222;
    b_raddr = {4{3'd7}}; b_dbg_addr = 3'd7;
    #2;
    n_tests++; if (a_rdata !== {2{32'h2222}}) begin n_fail++; $display("FAIL coll_bypass: got %h expected 2222 x2", a_rdata); end
    n_tests++; if (a_dbg_data !== 32'h0) begin n_fail++; $display("FAIL coll_dbg_same: got %h expected 0", a_dbg_data); end
    n_tests++; if (b_rdata !== 64'h0) begin n_fail++; $display("FAIL coll_b_same: got %h expected 0", b_rdata); end
    tick();
    idle_inputs();
    #2;
    n_tests++; if (a_rdata !== {2{32'h2222}}) begin n_fail++; $display("FAIL coll_stored: got %h expected 2222 x2", a_rdata); end
    n_tests++; if (a_dbg_data !== 32'h2222) begin n_fail++; $display("FAIL coll_dbg_next: got %h expected 2222", a_dbg_data); end
    n_tests++; if (b_rdata !== {4{16'h2222}}) begin n_fail++; $display("FAIL coll_b_stored: got %h expected 2222 x4", b_rdata); end
    n_tests++; if (b_dbg_data !== 16'h2222) begin n_fail++; $display("FAIL coll_b_dbg: got %h expected 2222", b_dbg_data); end
  endtask

  task automatic test_scoreboard();
    tick();
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9; a_raddr = {5'd9, 5'd9};
    b_rsv_en = 1'b1; b_rsv_addr = 3'd1; b_raddr = {4{3'd1}};
    #2;
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL sb_rsv_same_a: got %b expected 00", a_rbusy); end
    n_tests++; if (b_rbusy !== 4'h0) begin n_fail++; $display("FAIL sb_rsv_same_b: got %b expected 0000", b_rbusy); end
    tick();
    idle_inputs();
    #2;
    n_tests++; if (a_rbusy !== 2'b11) begin n_fail++; $display("FAIL sb_busy_a: got %b expected 11", a_rbusy); end
    n_tests++; if (b_rbusy !== 4'hF) begin n_fail++; $display("FAIL sb_busy_b: got %b expected 1111", b_rbusy); end
    tick();
    a_we1 = 1'b1; a_waddr1 = 5'd9; a_wdata1 = 32'hA5A5;
    b_we0 = 1'b1; b_waddr0 = 3'd1; b_wdata0 = 16'hA5A5;
    #2;
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL sb_wb_busy_a: got %b expected 00", a_rbusy); end
    n_tests++; if (a_rdata !== {2{32'hA5A5}}) begin n_fail++; $display("FAIL sb_wb_data_a: got %h expected a5a5 x2", a_rdata); end
    n_tests++; if (b_rbusy !== 4'hF) begin n_fail++; $display("FAIL sb_wb_busy_b: got %b expected 1111", b_rbusy); end
    n_tests++; if (b_rdata !== 64'h0) begin n_fail++; $display("FAIL sb_wb_data_b: got %h expected 0", b_rdata); end
    tick();
    idle_inputs();
    #2;
    n_tests++; if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL sb_after_busy_a: got %b expected 00", a_rbusy); end
    n_tests++; if (b_rbusy !== 4'h0) begin n_fail++; $display("FAIL sb_after_busy_b: got %b expected 0000", b_rbusy); end
    n_tests++; if (b_rdata !== {4{16'hA5A5}}) begin n_fail++; $display("FAIL sb_after_data_b: got %h expected a5a5 x4", b_rdata); end
  endtask

  task automatic test_race();
    tick();
    a_rsv_en = 1'b1; a_rsv_addr = 5'd3;
    a_we0 = 1'b1; a_waddr0 = 5'd3; a_wdata0 = 32'h3333_0003;
    a_raddr = {5'd3, 5'd3}; a_dbg_addr = 5'd3;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd3;
    b_we0 = 1'b1; b_waddr0 = 3'd3; b_wdata0 = 16'h3303;
    b_raddr = {4{3'd3}}; b_dbg_addr = 3'd3;
    tick();
    idle_inputs();
    #2;
    n_tests++; if (a_rbusy !== 2'b11) begin n_fail++; $display("FAIL race_busy_a: got %b expected 11", a_rbusy); end
    n_tests++; if (a_dbg_data !== 32'h3333_0003) begin n_fail++; $display("FAIL race_dbg_a: got %h expected 33330003", a_dbg_data); end
    n_tests++; if (a_rdata !== {2{32'h3333_0003}}) begin n_fail++; $display("FAIL race_rdata_a: got %h expected 33330003 x2", a_rdata); end
    n_tests++; if (b_rbusy !== 4'hF) begin n_fail++; $display("FAIL race_busy_b: got %b expected 1111", b_rbusy); end
    n_tests++; if (b_dbg_data !== 16'h3303) begin n_fail++; $display("FAIL race_dbg_b: got %h expected 3303", b_dbg_data); end
  endtask

  task automatic test_random();
    logic [4:0]  ra;
    logic [2:0]  rb;
    logic [31:0] ed;
    logic [31:0] e;
    logic [1:0]  a_eb;
    logic [3:0]  b_eb;
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin ma_reg[i] = '0; ma_pend[i] = 1'b0; end
    for (int i = 0; i < 8; i++)  begin mb_reg[i] = '0; mb_pend[i] = 1'b0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      a_we0 = 1'($urandom_range(0, 1)); a_waddr0 = rand_a(); a_wdata0 = $urandom();
      a_we1 = 1'($urandom_range(0, 1)); a_waddr1 = rand_a(); a_wdata1 = $urandom();
      a_rsv_en = ($urandom_range(0, 4) < 2); a_rsv_addr = rand_a();
      a_raddr = {rand_a(), rand_a()}; a_dbg_addr = rand_a();
      b_we0 = 1'($urandom_range(0, 1)); b_waddr0 = 3'($urandom_range(0, 7)); b_wdata0 = 16'($urandom());
      b_we1 = 1'($urandom_range(0, 1)); b_waddr1 = 3'($urandom_range(0, 7)); b_wdata1 = 16'($urandom());
      b_rsv_en = ($urandom_range(0, 4) < 2); b_rsv_addr = 3'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) b_raddr[k*3 +: 3] = 3'($urandom_range(0, 7));
      b_dbg_addr = 3'($urandom_range(0, 7));
      #2;
      // u_a: zero register plus same-cycle forwarding, port 1 first
      for (int k = 0; k < 2; k++) begin
        ra = a_raddr[k*5 +: 5];
        if (ra == 5'd0) begin
          ed = '0; a_eb[k] = 1'b0;
        end else if (a_we1 && a_waddr1 == ra) begin
          ed = a_wdata1; a_eb[k] = 1'b0;
        end else if (a_we0 && a_waddr0 == ra) begin
          ed = a_wdata0; a_eb[k] = 1'b0;
        end else begin
          ed = ma_reg[ra]; a_eb[k] = ma_pend[ra];
        end
        exp_q.push_back(ed);
      end
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        n_tests++; if (a_rdata[k*32 +: 32] !== e) begin n_fail++; $display("FAIL rand_a_rdata%0d cyc %0d: got %h expected %h", k, cyc, a_rdata[k*32 +: 32], e); end
      end
      n_tests++; if (a_rbusy !== a_eb) begin n_fail++; $display("FAIL rand_a_rbusy cyc %0d: got %b expected %b", cyc, a_rbusy, a_eb); end
      n_tests++; if (a_dbg_data !== ma_reg[a_dbg_addr]) begin n_fail++; $display("FAIL rand_a_dbg cyc %0d: got %h expected %h", cyc, a_dbg_data, ma_reg[a_dbg_addr]); end
      // u_b: plain stored state
      for (int k = 0; k < 4; k++) begin
        rb = b_raddr[k*3 +: 3];
        exp_q.push_back({16'h0, mb_reg[rb]});
        b_eb[k] = mb_pend[rb];
      end
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        n_tests++; if (b_rdata[k*16 +: 16] !== e[15:0]) begin n_fail++; $display("FAIL rand_b_rdata%0d cyc %0d: got %h expected %h", k, cyc, b_rdata[k*16 +: 16], e[15:0]); end
      end
      n_tests++; if (b_rbusy !== b_eb) begin n_fail++; $display("FAIL rand_b_rbusy cyc %0d: got %b expected %b", cyc, b_rbusy, b_eb); end
      n_tests++; if (b_dbg_data !== mb_reg[b_dbg_addr]) begin n_fail++; $display("FAIL rand_b_dbg cyc %0d: got %h expected %h", cyc, b_dbg_data, mb_reg[b_dbg_addr]); end
      @(posedge clk);
      if (a_we0 && a_waddr0 != 5'd0) begin ma_reg[a_waddr0] = a_wdata0; ma_pend[a_waddr0] = 1'b0; end
      if (a_we1 && a_waddr1 != 5'd0) begin ma_reg[a_waddr1] = a_wdata1; ma_pend[a_waddr1] = 1'b0; end
      if (a_rsv_en && a_rsv_addr != 5'd0) ma_pend[a_rsv_addr] = 1'b1;
      if (b_we0) begin mb_reg[b_waddr0] = b_wdata0; mb_pend[b_waddr0] = 1'b0; end
      if (b_we1) begin mb_reg[b_waddr1] = b_wdata1; mb_pend[b_waddr1] = 1'b0; end
      if (b_rsv_en) mb_pend[b_rsv_addr] = 1'b1;
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_collision();
    test_scoreboard();
    test_race();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
